mantissa_divider_seq: RTL and testbench

//  Sequential restoring divider for the f_divider datapath: computes 1.f0 / 1.f1 for two

---
 rtl/mantissa_divider_seq.sv | 130 +++++++++++++
 tb/tb_mantissa_divider_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mantissa_divider_seq.sv
// Sequential restoring mantissa divider: 1.f0 / 1.f1, BITS_PER_CYCLE quotient bits per clock.
// Produces QW quotient bits (incl. guard/round), sticky and quotient<1 flag; one op in flight.
module mantissa_divider_seq #(
  parameter int MAN_WIDTH      = 23,
  parameter int GRS_BITS       = 2,
  parameter int BITS_PER_CYCLE = 1,
  localparam int QW            = MAN_WIDTH + GRS_BITS + 1,
  localparam int NCYC          = QW / BITS_PER_CYCLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_WIDTH-1:0] in0_man,
  input  logic [MAN_WIDTH-1:0] in1_man,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QW-1:0]        quot,
  output logic                 lt_one,
  output logic                 sticky,
  output logic                 busy
);

  localparam int RW = MAN_WIDTH + 2;
  localparam int CW = $clog2(NCYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [RW-1:0]   r_rem;
  logic [RW-1:0]   r_div;
  logic [QW-1:0]   r_q;
  logic [CW-1:0]   r_cnt;
  logic [QW-1:0]   r_quot;
  logic            r_lt_one;
  logic            r_sticky;
  logic [RW-1:0]   w_rem;
  logic [QW-1:0]   w_q;

  // Partial remainder stays below 2*divisor, so RW bits suffice for compare, subtract and shift.
  always_comb begin
    w_rem = r_rem;
    w_q   = r_q;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (w_rem >= r_div) begin
        w_rem = w_rem - r_div;
        w_q   = {w_q[QW-2:0], 1'b1};
      end else begin
        w_q   = {w_q[QW-2:0], 1'b0};
      end
      w_rem = w_rem << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    if (flush) begin
      w_nstate = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)               w_nstate = CALC;
        CALC:    if (r_cnt == '0)            w_nstate = DONE;
        DONE:    if (out_ready)              w_nstate = IDLE;
        default:                             w_nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_lt_one <= 1'b0;
      r_sticky <= 1'b0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_quot   <= '0;
      r_lt_one <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem <= {2'b01, in0_man};
            r_div <= {2'b01, in1_man};
            r_q   <= '0;
            r_cnt <= CNT_LAST;
          end
        end
        CALC: begin
          r_rem <= w_rem;
          r_q   <= w_q;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_quot   <= w_q;
            r_lt_one <= ~w_q[QW-1];
            r_sticky <= |w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC) || (r_state == DONE);
  assign quot      = r_quot;
  assign lt_one    = r_lt_one;
  assign sticky    = r_sticky;

endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Scoreboard bench for mantissa_divider_seq: directed operands with hand-computed quotients,
// one DUT at 1 bit/cycle and one at 2 bits/cycle; monitors pop expectations on each handshake.
module tb_mantissa_divider_seq;

  typedef struct {
    logic [25:0] q;
    logic        lt;
    logic        st;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        iv1 = 1'b0, fl1 = 1'b0, or1 = 1'b1;
  logic [22:0] a1 = '0, b1 = '0;
  logic        ir1, ov1, lt1, st1, bz1;
  logic [25:0] q1o;

  logic        iv2 = 1'b0, or2 = 1'b1;
  logic [22:0] a2 = '0, b2 = '0;
  logic        ir2, ov2, lt2, st2, bz2;
  logic [25:0] q2o;

  exp_t sb1[$];
  exp_t sb2[$];
  int   rise1 = 0, rise2 = 0, nrise1 = 0;
  logic pov1 = 1'b0, pov2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mantissa_divider_seq #(.MAN_WIDTH(23), .GRS_BITS(2), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in0_man(a1), .in1_man(b1),
    .flush(fl1), .out_valid(ov1), .out_ready(or1), .quot(q1o), .lt_one(lt1), .sticky(st1),
    .busy(bz1));

  mantissa_divider_seq #(.MAN_WIDTH(23), .GRS_BITS(2), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in0_man(a2), .in1_man(b2),
    .flush(1'b0), .out_valid(ov2), .out_ready(or2), .quot(q2o), .lt_one(lt2), .sticky(st2),
    .busy(bz2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e, input logic [25:0] q, input logic lt, input logic st,
                         input int rise);
    check($sformatf("quot[%0d]", e.id), {6'd0, q}, {6'd0, e.q});
    check($sformatf("lt_one[%0d]", e.id), {31'd0, lt}, {31'd0, e.lt});
    check($sformatf("sticky[%0d]", e.id), {31'd0, st}, {31'd0, e.st});
    check($sformatf("latency[%0d]", e.id), rise - e.acc, e.lat);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pov1 = 1'b0;
    end else begin
      if (ov1 && !pov1) begin rise1 = cyc; nrise1++; end
      pov1 = ov1;
      if (ov1 && or1) begin
        if (sb1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out1: got out_valid=1 quot=%0h want no result", q1o);
        end else begin
          compare(sb1.pop_front(), q1o, lt1, st1, rise1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pov2 = 1'b0;
    end else begin
      if (ov2 && !pov2) rise2 = cyc;
      pov2 = ov2;
      if (ov2 && or2) begin
        if (sb2.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out2: got out_valid=1 quot=%0h want no result", q2o);
        end else begin
          compare(sb2.pop_front(), q2o, lt2, st2, rise2);
        end
      end
    end
  end

  task automatic issue1(input logic [22:0] a, input logic [22:0] b, input logic [25:0] eq,
                        input logic el, input logic es, input int id, input bit push);
    int t;
    exp_t e;
    t = 0;
    @(posedge clk); #1;
    while (!ir1 && t < 200) begin @(posedge clk); #1; t++; end
    if (!ir1) begin
      total++; bad++;
      $display("FAIL in_ready_timeout[%0d]: got in_ready=0 want 1", id);
      return;
    end
    a1 = a; b1 = b; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    if (push) begin
      e.q = eq; e.lt = el; e.st = es; e.lat = 26; e.acc = cyc; e.id = id;
      sb1.push_back(e);
    end
  endtask

  task automatic drain1;
    int t;
    t = 0;
    while (sb1.size() > 0 && t < 300) begin @(posedge clk); #1; t++; end
    check("drain1_timeout", sb1.size(), 0);
  endtask

  task automatic wait_ov1(input int id);
    int t;
    t = 0;
    while (!ov1 && t < 100) begin @(posedge clk); #1; t++; end
    check($sformatf("ov1_wait[%0d]", id), {31'd0, ov1}, 32'd1);
  endtask

  initial begin
    exp_t e;
    int t, nr;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_busy", {31'd0, bz1}, 32'd0);
    check("rst_quot", {6'd0, q1o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, ir1}, 32'd1);
    check("rst_lt_sticky", {30'd0, lt1, st1}, 32'd0);

    // Main function, several operand patterns
    issue1(23'h000000, 23'h000000, 26'h2000000, 1'b0, 1'b0, 1, 1);
    check("busy_in_calc", {31'd0, bz1}, 32'd1);
    check("in_ready_in_calc", {31'd0, ir1}, 32'd0);
    issue1(23'h600000, 23'h600000, 26'h2000000, 1'b0, 1'b0, 2, 1);
    issue1(23'h000000, 23'h400000, 26'h1555555, 1'b1, 1'b1, 3, 1);
    issue1(23'h7FFFFF, 23'h000000, 26'h3FFFFFC, 1'b0, 1'b0, 4, 1);
    issue1(23'h400000, 23'h000000, 26'h3000000, 1'b0, 1'b0, 5, 1);
    issue1(23'h000000, 23'h7FFFFF, 26'h1000001, 1'b1, 1'b1, 6, 1);
    drain1();

    // 2 bits per cycle
    @(posedge clk); #1;
    a2 = 23'h7FFFFF; b2 = 23'h000000; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    e.q = 26'h3FFFFFC; e.lt = 1'b0; e.st = 1'b0; e.lat = 13; e.acc = cyc; e.id = 7;
    sb2.push_back(e);
    check("busy2_in_calc", {31'd0, bz2}, 32'd1);
    t = 0;
    while (sb2.size() > 0 && t < 100) begin @(posedge clk); #1; t++; end
    check("drain2_timeout", sb2.size(), 0);

    // Backpressure: hold DONE for 5 cycles, extra in_valid must be ignored
    or1 = 1'b0;
    issue1(23'h000000, 23'h400000, 26'h1555555, 1'b1, 1'b1, 8, 1);
    wait_ov1(8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a1 = 23'h123456; b1 = 23'h654321; iv1 = 1'b1;
      check("stall_quot", {6'd0, q1o}, 32'h1555555);
      check("stall_flags", {29'd0, ov1, lt1, st1}, 32'd7);
      check("stall_in_ready", {31'd0, ir1}, 32'd0);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    drain1();
    nr = nrise1;
    repeat (35) @(posedge clk);
    #1;
    check("stall_no_extra", nrise1, nr);

    // Async reset in the middle of CALC
    issue1(23'h123456, 23'h054321, 26'h0, 1'b0, 1'b0, 9, 0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, ov1}, 32'd0);
    check("midrst_busy", {31'd0, bz1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", {31'd0, ir1}, 32'd1);

    // Flush during CALC: no result produced
    nr = nrise1;
    issue1(23'h000000, 23'h400000, 26'h0, 1'b0, 1'b0, 10, 0);
    repeat (5) @(posedge clk);
    #1;
    fl1 = 1'b1;
    @(posedge clk); #1;
    fl1 = 1'b0;
    check("flush_in_ready", {31'd0, ir1}, 32'd1);
    check("flush_busy", {31'd0, bz1}, 32'd0);
    repeat (35) @(posedge clk);
    #1;
    check("flush_no_result", nrise1, nr);

    // Flush in DONE clears held outputs
    or1 = 1'b0;
    issue1(23'h000000, 23'h400000, 26'h0, 1'b0, 1'b0, 11, 0);
    wait_ov1(11);
    fl1 = 1'b1;
    @(posedge clk); #1;
    fl1 = 1'b0;
    check("flushdone_out", {5'd0, ov1, q1o}, 32'd0);
    check("flushdone_flags", {30'd0, lt1, st1}, 32'd0);
    or1 = 1'b1;

    // Operation after flush still correct
    issue1(23'h600000, 23'h600000, 26'h2000000, 1'b0, 1'b0, 12, 1);
    drain1();
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb1.size() + sb2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
